frame_sync: RTL and testbench
=============================

Name: frame_sync

Overview:
- Sits directly downstream of bit_syn in the FSK demodulation chain.
- Consumes the recovered serial bit stream (one bit per bit_en strobe), hunts for a fixed sync word, confirms frame alignment, then delivers payload bytes MSB-first with a one-cycle valid strobe.
- Tracks loss of lock through a flywheel miss counter.

Parameters:
- SYNC_WORD, 16'hEB90, frame sync pattern; its MSB is received first.
- SYNC_LEN, 16, sync word length in bits.
- PAYLOAD_BYTES, 4, number of payload bytes following each sync word.
- CONFIRM, 2, consecutive sync hits needed to lock. The initial detect counts as hit 1.
- MISS_MAX, 2, consecutive sync misses in LOCK that force a return to SEARCH.

Ports:
- clk  input  1  system clock, 200 MHz.
- reset  input  1  asynchronous, active-low reset.
- bit_in  input  1  demodulated data bit from bit_syn; sampled only when bit_en=1.
- bit_en  input  1  one-cycle strobe, one per recovered bit. Spacing is arbitrary, minimum 1 cycle.
- data_out  output  8  payload byte.
- data_valid  output  1  one-cycle pulse; data_out is valid in this cycle.
- frame_start  output  1  one-cycle pulse when a sync word is accepted in LOCK, including the locking hit.
- locked  output  1  high while in LOCK.
- miss_cnt  output  2  current consecutive-miss count.

Behaviour:
- Reset (async, reset=0) clears all state:
  - state=SEARCH
  - shift register=0, k=0, hits=0, miss_cnt=0
  - data_out=8'h00, data_valid=0, frame_start=0, locked=0
- Derived constant: FRAME_BITS = SYNC_LEN + 8*PAYLOAD_BYTES (48 at defaults).
- Shifting and match:
  - On bit_en: sr <= {sr[SYNC_LEN-2:0], bit_in}.
  - Combinational match = ({sr[SYNC_LEN-2:0], bit_in} == SYNC_WORD), evaluated only in bit_en cycles.
  - Matching is exact; no bit-error tolerance.
- k counts bit_en strobes since the last accepted sync end (1..FRAME_BITS):
  - k = 1..8*PAYLOAD_BYTES are payload bits.
  - k = FRAME_BITS is the last bit of the next sync word (the compare point). k returns to 0 there.
- All outputs are registered. Response appears the cycle after the deciding bit_en.
- SEARCH:
  - match -> CHECK, hits=1, k=0.
  - No data_valid in this state.
- CHECK:
  - Counts bits only; no data output.
  - At k=FRAME_BITS: match -> hits+1. If hits+1 == CONFIRM -> LOCK with locked=1, frame_start=1, miss_cnt=0. Otherwise stay in CHECK with k=0.
  - At k=FRAME_BITS with mismatch -> SEARCH, hits=0.
  - The sliding compare is not evaluated in CHECK.
- LOCK:
  - Payload bits are shifted into a byte register MSB-first.
  - At k = 8, 16, ..., 8*PAYLOAD_BYTES: data_out <= assembled byte and data_valid=1 for exactly one cycle.
  - Compare at k=FRAME_BITS, match: miss_cnt=0, frame_start=1.
  - Compare at k=FRAME_BITS, mismatch: miss_cnt+1. Stay locked (flywheel); the next frame's payload is still output.
  - When miss_cnt+1 == MISS_MAX -> SEARCH: locked=0, miss_cnt=0, hits=0. That frame's payload is not output.
  - k wraps to 0 at every compare point, matched or not.
- Cycles without bit_en: all state holds; data_valid and frame_start are 0.
- Re-acquisition: the first bit_en after dropping to SEARCH is already evaluated against the sliding compare.
- data_out holds its last value between pulses.
- CONFIRM=1: a SEARCH match goes directly to LOCK with frame_start=1.
- Reset mid-operation: immediate return to the reset state.
  - A partially assembled byte is discarded.
  - No data_valid is emitted during or after reset until the block is re-locked.

Test Plan:
1. Reset/idle: hold reset=0 for 3260 ns with random bit_en/bit_in, then release while sending noise with no 16'hEB90 -> locked=0, data_valid never asserts, data_out=8'h00.
2. Acquisition: send 3 clean frames {EB90, 12 34 56 78}:
   - frame 1 sync -> CHECK;
   - frame 2 sync -> locked=1 and frame_start pulse;
   - data_valid pulses 4x with 12, 34, 56, 78 (frame 2 payload), then again 4x after frame 3 sync;
   - frame 1 payload is never output.
3. Flywheel: while locked, corrupt one sync (EB91) -> miss_cnt=1, locked stays 1, that frame's 4 bytes are still output. The next clean sync -> miss_cnt=0.
4. Loss of lock: while locked, corrupt two consecutive syncs -> locked falls the cycle after the 2nd compare, the second frame's payload gives no data_valid, miss_cnt=0. Clean frames then re-acquire as in scenario 2.
5. False sync: in SEARCH send payload bytes EB 90 followed by a frame whose bit FRAME_BITS later is not a sync -> CHECK then back to SEARCH, zero data_valid. The real sync stream after that locks normally.
6. Strobe spacing and reset: repeat scenario 2 with bit_en gaps of 1, 7 and 40 cycles -> byte sequence is identical. Then assert reset during the 2nd byte of a locked frame -> locked=0, data_valid=0 immediately, and no partial byte appears after release.

Source files
------------

// File: rtl/frame_sync.sv
// Frame synchroniser: hunts for SYNC_WORD in the recovered bit stream, confirms
// alignment over CONFIRM frames, then emits payload bytes with a flywheel lock.
module frame_sync #(
  parameter int                  SYNC_LEN      = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD     = 16'hEB90,
  parameter int                  PAYLOAD_BYTES = 4,
  parameter int                  CONFIRM       = 2,
  parameter int                  MISS_MAX      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_en,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_start,
  output logic       locked,
  output logic [1:0] miss_cnt
);

  localparam int PAYLOAD_BITS = 8 * PAYLOAD_BYTES;
  localparam int FRAME_BITS   = SYNC_LEN + PAYLOAD_BITS;
  localparam int KW           = $clog2(FRAME_BITS + 1);
  localparam int HW           = $clog2(CONFIRM + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t              state_reg;
  // The oldest sync bit is shifted out on the compare cycle, so it is never stored.
  logic [SYNC_LEN-2:0] sr_reg;
  logic [KW-1:0]       k_reg;
  logic [HW-1:0]       hits_reg;
  logic [6:0]          byte_reg;

  logic [SYNC_LEN-1:0] shifted;
  logic                match;
  logic [KW-1:0]       k_inc;
  logic                at_compare;
  logic                payload_bit;
  logic                byte_done;
  logic [HW-1:0]       hits_inc;
  logic [1:0]          miss_inc;

  always_comb begin
    shifted     = {sr_reg, bit_in};
    match       = (shifted == SYNC_WORD);
    k_inc       = k_reg + 1'b1;
    at_compare  = (k_inc == KW'(FRAME_BITS));
    payload_bit = (k_inc <= KW'(PAYLOAD_BITS));
    byte_done   = payload_bit && (k_inc[2:0] == 3'd0);
    hits_inc    = hits_reg + 1'b1;
    miss_inc    = miss_cnt + 2'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= SEARCH;
      sr_reg      <= '0;
      k_reg       <= '0;
      hits_reg    <= '0;
      byte_reg    <= '0;
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      miss_cnt    <= 2'd0;
    end else begin
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      if (bit_en) begin
        sr_reg <= shifted[SYNC_LEN-2:0];
        case (state_reg)
          SEARCH: begin
            if (match) begin
              hits_reg <= HW'(1);
              k_reg    <= '0;
              if (CONFIRM == 1) begin
                state_reg   <= LOCK;
                locked      <= 1'b1;
                frame_start <= 1'b1;
                miss_cnt    <= 2'd0;
              end else begin
                state_reg <= CHECK;
              end
            end
          end

          CHECK: begin
            if (at_compare) begin
              k_reg <= '0;
              if (!match) begin
                state_reg <= SEARCH;
                hits_reg  <= '0;
              end else begin
                hits_reg <= hits_inc;
                if (hits_inc == HW'(CONFIRM)) begin
                  state_reg   <= LOCK;
                  locked      <= 1'b1;
                  frame_start <= 1'b1;
                  miss_cnt    <= 2'd0;
                end
              end
            end else begin
              k_reg <= k_inc;
            end
          end

          LOCK: begin
            if (payload_bit) begin
              byte_reg <= {byte_reg[5:0], bit_in};
            end
            if (byte_done) begin
              data_out   <= {byte_reg, bit_in};
              data_valid <= 1'b1;
            end
            if (at_compare) begin
              k_reg <= '0;
              if (match) begin
                miss_cnt    <= 2'd0;
                frame_start <= 1'b1;
              end else if (miss_inc == 2'(MISS_MAX)) begin
                // Flywheel exhausted: the payload after this sync is dropped.
                state_reg <= SEARCH;
                locked    <= 1'b0;
                miss_cnt  <= 2'd0;
                hits_reg  <= '0;
              end else begin
                miss_cnt <= miss_inc;
              end
            end else begin
              k_reg <= k_inc;
            end
          end

          default: begin
            state_reg <= SEARCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_sync.sv
// Bench for frame_sync: frame-level vector table, hand-built corner sequences and
// random traffic, all checked bit by bit against a frame-rule reference model.
`timescale 1ns/1ps
module tb_frame_sync;

  localparam logic [15:0] SYNC       = 16'hEB90;
  localparam int          PAY_BITS   = 32;
  localparam int          FRAME_BITS = 48;
  localparam int          CONFIRM    = 2;
  localparam int          MISS_MAX   = 2;
  localparam int          M_SEARCH   = 0;
  localparam int          M_CHECK    = 1;
  localparam int          M_LOCK     = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_en = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_start;
  logic       locked;
  logic [1:0] miss_cnt;

  always #2.5 clk = ~clk;

  frame_sync dut (
    .clk         (clk),
    .reset       (reset),
    .bit_in      (bit_in),
    .bit_en      (bit_en),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_start (frame_start),
    .locked      (locked),
    .miss_cnt    (miss_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: last 16 bits seen, frame position, and lock bookkeeping.
  logic [15:0] m_hist;
  int          m_mode, m_pos, m_hits, m_miss;
  logic        m_valid, m_fs;
  logic [7:0]  m_data;
  logic [7:0]  got_q[$];

  typedef struct {
    logic [15:0] sync;
    logic [31:0] payload;
    int          gap;
    logic        exp_locked;
    logic [1:0]  exp_miss;
    int          exp_bytes;
  } fvec_t;

  fvec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist  = '0;
    m_mode  = M_SEARCH;
    m_pos   = 0;
    m_hits  = 0;
    m_miss  = 0;
    m_valid = 1'b0;
    m_fs    = 1'b0;
    m_data  = 8'h00;
  endtask

  task automatic model_step(input logic b);
    logic hit;
    m_valid = 1'b0;
    m_fs    = 1'b0;
    m_hist  = {m_hist[14:0], b};
    hit     = (m_hist == SYNC);
    case (m_mode)
      M_SEARCH: begin
        if (hit) begin
          m_mode = M_CHECK;
          m_hits = 1;
          m_pos  = 0;
        end
      end
      M_CHECK: begin
        m_pos++;
        if (m_pos == FRAME_BITS) begin
          m_pos = 0;
          if (!hit) begin
            m_mode = M_SEARCH;
            m_hits = 0;
          end else begin
            m_hits++;
            if (m_hits == CONFIRM) begin
              m_mode = M_LOCK;
              m_fs   = 1'b1;
              m_miss = 0;
            end
          end
        end
      end
      default: begin
        m_pos++;
        // A payload byte is simply the last eight bits received.
        if (m_pos <= PAY_BITS && m_pos % 8 == 0) begin
          m_valid = 1'b1;
          m_data  = m_hist[7:0];
        end
        if (m_pos == FRAME_BITS) begin
          m_pos = 0;
          if (hit) begin
            m_miss = 0;
            m_fs   = 1'b1;
          end else begin
            m_miss++;
            if (m_miss == MISS_MAX) begin
              m_mode = M_SEARCH;
              m_miss = 0;
              m_hits = 0;
            end
          end
        end
      end
    endcase
  endtask

  task automatic check_resp(input string name);
    if (data_valid === 1'b1) got_q.push_back(data_out);
    check(name, 32'({data_valid, frame_start, locked, miss_cnt, data_out}),
          32'({m_valid, m_fs, (m_mode == M_LOCK), 2'(m_miss), m_data}));
  endtask

  // Called at a negedge; drives one strobe, then gap idle cycles (gap<0: random 0..2).
  task automatic send_bit(input logic b, input int gap);
    int g;
    g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    bit_en = 1'b1;
    bit_in = b;
    model_step(b);
    @(negedge clk);
    bit_en = 1'b0;
    bit_in = 1'($urandom);
    check_resp("bit_resp");
    m_valid = 1'b0;
    m_fs    = 1'b0;
    repeat (g) begin
      @(negedge clk);
      bit_in = 1'($urandom);
      check_resp("idle_resp");
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits, input int gap);
    for (int i = nbits - 1; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset  = 1'b0;
    model_reset();
    repeat (cycles) begin
      bit_en = 1'($urandom);
      bit_in = 1'($urandom);
      @(negedge clk);
      check("reset_outputs", 32'({data_valid, frame_start, locked, miss_cnt, data_out}), 32'h0);
    end
    bit_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b;
    int   r;
    tbl[0]  = '{16'hEB90, 32'h12345678,  0, 1'b0, 2'd0, 0};
    tbl[1]  = '{16'hEB90, 32'h12345678,  0, 1'b1, 2'd0, 4};
    tbl[2]  = '{16'hEB90, 32'h12345678,  0, 1'b1, 2'd0, 4};
    tbl[3]  = '{16'hEB91, 32'hAABBCCDD,  0, 1'b1, 2'd1, 4};
    tbl[4]  = '{16'hEB90, 32'h12345678,  0, 1'b1, 2'd0, 4};
    tbl[5]  = '{16'hEB91, 32'h12345678,  0, 1'b1, 2'd1, 4};
    tbl[6]  = '{16'hEB91, 32'h12345678,  0, 1'b0, 2'd0, 0};
    tbl[7]  = '{16'hEB90, 32'h12345678,  0, 1'b0, 2'd0, 0};
    tbl[8]  = '{16'hEB90, 32'h12345678,  0, 1'b1, 2'd0, 4};
    tbl[9]  = '{16'hEB90, 32'h12345678,  1, 1'b1, 2'd0, 4};
    tbl[10] = '{16'hEB90, 32'h12345678,  7, 1'b1, 2'd0, 4};
    tbl[11] = '{16'hEB90, 32'h12345678, 40, 1'b1, 2'd0, 4};

    // Long reset with activity, then sync-free noise.
    model_reset();
    do_reset(652);
    got_q.delete();
    for (int i = 0; i < 300; i++) begin
      b = 1'($urandom);
      if ({m_hist[14:0], b} == SYNC) b = ~b;
      send_bit(b, -1);
    end
    check("noise_locked", 32'(locked), 32'h0);
    check("noise_data_out", 32'(data_out), 32'h0);
    check("noise_valid_count", 32'(got_q.size()), 32'h0);

    // Acquisition, flywheel, loss of lock, re-acquisition, strobe gaps.
    do_reset(4);
    for (int f = 0; f < 12; f++) begin
      send_word(32'(tbl[f].sync), 16, tbl[f].gap);
      check($sformatf("frame%0d_locked", f), 32'(locked), 32'(tbl[f].exp_locked));
      check($sformatf("frame%0d_miss", f), 32'(miss_cnt), 32'(tbl[f].exp_miss));
      got_q.delete();
      send_word(tbl[f].payload, 32, tbl[f].gap);
      check($sformatf("frame%0d_nbytes", f), 32'(got_q.size()), 32'(tbl[f].exp_bytes));
      if (tbl[f].exp_bytes == 4 && got_q.size() == 4)
        check($sformatf("frame%0d_bytes", f), {got_q[0], got_q[1], got_q[2], got_q[3]},
              tbl[f].payload);
    end

    // False sync inside data: CHECK, then back to SEARCH, then a real lock.
    do_reset(4);
    got_q.delete();
    send_word(32'h0000EB90, 16, 0);
    send_word(32'h12345678, 32, 0);
    send_word(32'h00009ABC, 16, 0);
    check("false_sync_locked", 32'(locked), 32'h0);
    check("false_sync_nbytes", 32'(got_q.size()), 32'h0);
    send_word(32'h0000EB90, 16, 0);
    send_word(32'h12345678, 32, 0);
    send_word(32'h0000EB90, 16, 0);
    check("relock_locked", 32'(locked), 32'h1);
    got_q.delete();
    send_word(32'hA1B2C3D4, 32, 0);
    check("relock_nbytes", 32'(got_q.size()), 32'h4);
    if (got_q.size() == 4)
      check("relock_bytes", {got_q[0], got_q[1], got_q[2], got_q[3]}, 32'hA1B2C3D4);

    // Asynchronous reset part way through the second byte of a locked frame.
    send_word(32'h0000EB90, 16, 0);
    send_word(32'h00000055, 8, 0);
    send_word(32'h00000005, 3, 0);
    #1 reset = 1'b0;
    model_reset();
    #0.5;
    check("async_reset_locked", 32'(locked), 32'h0);
    check("async_reset_valid", 32'(data_valid), 32'h0);
    check("async_reset_data", 32'(data_out), 32'h0);
    @(negedge clk);
    repeat (5) begin
      bit_en = 1'($urandom);
      @(negedge clk);
    end
    bit_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    got_q.delete();
    send_word(32'h00000000, 32, 0);
    send_word(32'h00000000, 32, 0);
    check("post_reset_nbytes", 32'(got_q.size()), 32'h0);
    check("post_reset_locked", 32'(locked), 32'h0);

    // Random mix of clean frames, corrupted syncs and raw noise.
    do_reset(3);
    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 3));
      if (r <= 1) begin
        send_word(32'(SYNC), 16, -1);
        send_word($urandom, 32, -1);
      end else if (r == 2) begin
        send_word(32'(SYNC ^ (16'h1 << $urandom_range(0, 15))), 16, -1);
        send_word($urandom, 32, -1);
      end else begin
        send_word($urandom, int'($urandom_range(1, 20)), -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
